// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB slave between two APB masters; grant held for a full transfer.
// Adds one wait state (SETUP at T+1, ACCESS at T+2); a stalled slave is aborted after TIMEOUT wait cycles.
module apb_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_SIZE  = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_sel,
    input  logic                  m0_enable,
    input  logic                  m0_write,
    input  logic [STRB_SIZE-1:0]  m0_strobe,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ready,
    output logic                  m0_slverr,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_sel,
    input  logic                  m1_enable,
    input  logic                  m1_write,
    input  logic [STRB_SIZE-1:0]  m1_strobe,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ready,
    output logic                  m1_slverr,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  s_sel,
    output logic                  s_enable,
    output logic                  s_write,
    output logic [STRB_SIZE-1:0]  s_strobe,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_wdata,
    input  logic                  s_ready,
    input  logic                  s_slverr,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            gnt,
    output logic                  busy,
    output logic                  timeout_evt
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state, state_nxt;
    logic [1:0]    gnt_nxt;
    logic          last_grant, last_grant_nxt;   // 1 = m1 was granted last
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          done, abort, pick1;

    // The masters' enable phase carries no arbitration information.
    logic unused_en;
    assign unused_en = m0_enable ^ m1_enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= 2'b00;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            last_grant <= last_grant_nxt;
            wait_cnt   <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        gnt_nxt        = gnt;
        last_grant_nxt = last_grant;
        wait_cnt_nxt   = wait_cnt;
        s_sel          = 1'b0;
        s_enable       = 1'b0;
        done           = 1'b0;
        abort          = 1'b0;
        pick1          = 1'b0;
        case (state)
            IDLE: begin
                if (m0_sel || m1_sel) begin
                    pick1          = m1_sel && (!m0_sel || !last_grant);
                    gnt_nxt        = pick1 ? 2'b10 : 2'b01;
                    last_grant_nxt = pick1;
                    state_nxt      = SETUP;
                end
            end
            SETUP: begin
                s_sel        = 1'b1;
                wait_cnt_nxt = '0;
                state_nxt    = ACCESS;
            end
            ACCESS: begin
                s_sel    = 1'b1;
                s_enable = 1'b1;
                if (s_ready) begin
                    done      = 1'b1;
                    gnt_nxt   = 2'b00;
                    state_nxt = IDLE;
                end else if ((TIMEOUT > 0) && (wait_cnt == TMAX)) begin
                    abort     = 1'b1;
                    gnt_nxt   = 2'b00;
                    state_nxt = IDLE;
                end else if (wait_cnt != TMAX) begin
                    wait_cnt_nxt = wait_cnt + CW'(1);
                end
            end
            default: begin
                gnt_nxt   = 2'b00;
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy        = (state != IDLE);
    assign timeout_evt = abort;

    always_comb begin
        s_write  = 1'b0;
        s_strobe = '0;
        s_addr   = '0;
        s_wdata  = '0;
        if (busy) begin
            s_write  = gnt[1] ? m1_write  : m0_write;
            s_strobe = gnt[1] ? m1_strobe : m0_strobe;
            s_addr   = gnt[1] ? m1_addr   : m0_addr;
            s_wdata  = gnt[1] ? m1_wdata  : m0_wdata;
        end
    end

    // A master that dropped sel mid-transfer gets no response; the slave side still completes.
    assign m0_ready  = (done || abort) && gnt[0] && m0_sel;
    assign m1_ready  = (done || abort) && gnt[1] && m1_sel;
    assign m0_slverr = m0_ready && (abort || s_slverr);
    assign m1_slverr = m1_ready && (abort || s_slverr);
    assign m0_rdata  = (m0_ready && done) ? s_rdata : '0;
    assign m1_rdata  = (m1_ready && done) ? s_rdata : '0;
endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter (TIMEOUT=4): arbitration order, latency, wait states, timeout, reset.
module tb_apb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        m0_sel, m0_enable, m0_write;
    logic [1:0]  m0_strobe;
    logic [31:0] m0_addr, m0_wdata;
    logic        m0_ready, m0_slverr;
    logic [31:0] m0_rdata;
    logic        m1_sel, m1_enable, m1_write;
    logic [1:0]  m1_strobe;
    logic [31:0] m1_addr, m1_wdata;
    logic        m1_ready, m1_slverr;
    logic [31:0] m1_rdata;
    logic        s_sel, s_enable, s_write;
    logic [1:0]  s_strobe;
    logic [31:0] s_addr, s_wdata;
    logic        s_ready, s_slverr;
    logic [31:0] s_rdata;
    logic [1:0]  gnt;
    logic        busy, timeout_evt;

    int n_vec  = 0;
    int n_miss = 0;

    apb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_SIZE(2), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_sel(m0_sel), .m0_enable(m0_enable), .m0_write(m0_write), .m0_strobe(m0_strobe),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_slverr(m0_slverr),
        .m0_rdata(m0_rdata),
        .m1_sel(m1_sel), .m1_enable(m1_enable), .m1_write(m1_write), .m1_strobe(m1_strobe),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_slverr(m1_slverr),
        .m1_rdata(m1_rdata),
        .s_sel(s_sel), .s_enable(s_enable), .s_write(s_write), .s_strobe(s_strobe),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_ready(s_ready), .s_slverr(s_slverr),
        .s_rdata(s_rdata),
        .gnt(gnt), .busy(busy), .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_sel = 0; m0_enable = 0; m0_write = 0; m0_strobe = 0; m0_addr = 0; m0_wdata = 0;
        m1_sel = 0; m1_enable = 0; m1_write = 0; m1_strobe = 0; m1_addr = 0; m1_wdata = 0;
        s_ready = 0; s_slverr = 0; s_rdata = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] eg;
        do_reset();

        // Reset state
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ssel_en", {s_sel, s_enable}, 2'b00);
        chk("rst_ready", {m0_ready, m1_ready, m0_slverr, m1_slverr, timeout_evt}, 5'b0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
        chk("rst_saddr", s_addr, 32'd0);

        // Single write, zero-wait slave
        m0_sel = 1; m0_write = 1; m0_strobe = 2'd2; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
        s_ready = 1;
        step();
        m0_enable = 1;
        #1;
        chk("wr_gnt_T1", gnt, 2'b01);
        chk("wr_setup_sel_en", {s_sel, s_enable, busy}, 3'b101);
        chk("wr_setup_ready", m0_ready, 1'b0);
        step();
        chk("wr_access_sel_en", {s_sel, s_enable}, 2'b11);
        chk("wr_saddr", s_addr, 32'h10);
        chk("wr_swdata", s_wdata, 32'hDEADBEEF);
        chk("wr_swrite_strobe", {s_write, s_strobe}, 3'b110);
        chk("wr_m0_ready", {m0_ready, m0_slverr}, 2'b10);
        step();
        clear_inputs();
        #1;
        chk("wr_gnt_T3", {gnt, busy, s_sel}, 4'b0000);

        // Simultaneous reads after reset: m0 first, then m1
        do_reset();
        m0_sel = 1; m0_addr = 32'h4; m1_sel = 1; m1_addr = 32'h8;
        s_ready = 1; s_rdata = 32'h0000000A;
        step();
        chk("sim_gnt_m0", gnt, 2'b01);
        chk("sim_saddr_m0", s_addr, 32'h4);
        step();
        chk("sim_m0_ready", {m0_ready, m1_ready}, 2'b10);
        chk("sim_m0_rdata", m0_rdata, 32'hA);
        chk("sim_m1_rdata_idle", m1_rdata, 32'h0);
        chk("sim_swrite", s_write, 1'b0);
        step();
        m0_sel = 0; s_rdata = 32'h0000000B;
        #1;
        chk("sim_gap_idle", {s_sel, gnt, m1_ready}, 4'b0000);
        step();
        chk("sim_gnt_m1", gnt, 2'b10);
        chk("sim_saddr_m1", s_addr, 32'h8);
        chk("sim_m1_setup_ready", m1_ready, 1'b0);
        step();
        chk("sim_m1_ready", {m0_ready, m1_ready}, 2'b01);
        chk("sim_m1_rdata", m1_rdata, 32'hB);
        step();
        clear_inputs();

        // Continuous load: strict alternation
        do_reset();
        m0_sel = 1; m1_sel = 1; s_ready = 1;
        for (int i = 0; i < 6; i++) begin
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            step();
            chk($sformatf("rr_gnt_%0d", i), gnt, eg);
            step();
            chk($sformatf("rr_ready_%0d", i), {m1_ready, m0_ready}, eg);
            step();
            chk($sformatf("rr_idle_%0d", i), {busy, s_sel}, 2'b00);
        end
        clear_inputs();

        // Wait states: 3 low ACCESS cycles, ready on the 4th
        step();
        m0_sel = 1; m0_addr = 32'h20;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("ws_wait_%0d", i), {m0_ready, timeout_evt, s_enable}, 3'b001);
        end
        step();
        s_ready = 1; s_rdata = 32'h12345678;
        #1;
        chk("ws_ready", {m0_ready, m0_slverr, timeout_evt}, 3'b100);
        chk("ws_rdata", m0_rdata, 32'h12345678);
        step();
        clear_inputs();

        // Timeout abort after 4 wait cycles; late s_ready ignored
        step();
        m0_sel = 1; m0_addr = 32'h30; s_rdata = 32'hCAFEF00D;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("to_wait_%0d", i), {m0_ready, timeout_evt}, 2'b00);
        end
        step();
        chk("to_abort", {m0_ready, m0_slverr, timeout_evt}, 3'b111);
        chk("to_rdata", m0_rdata, 32'h0);
        step();
        m0_sel = 0; s_ready = 1;
        #1;
        chk("to_after", {busy, gnt, m0_ready, timeout_evt, s_sel}, 6'b0);
        step();
        chk("to_late_ready", {busy, m0_ready, m0_slverr}, 3'b000);
        clear_inputs();

        // Reset mid-ACCESS, then both request: m0 wins
        m0_sel = 1; m0_addr = 32'h40;
        step();
        step();
        chk("mr_in_access", {s_sel, s_enable, gnt}, 4'b1101);
        rst = 1;
        step();
        chk("mr_after_rst", {s_sel, s_enable, gnt, busy, m0_ready}, 6'b0);
        rst = 0; m1_sel = 1; m1_addr = 32'h44;
        step();
        chk("mr_gnt_m0", gnt, 2'b01);
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
